// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin arbiter sharing one easySerialOut transmitter
//
// Purpose: grants one of N_REQ requesters, latches its message, drives the
// transmitter EN/msg/SB inputs and holds the grant for a whole frame.
// Ports:
//   CLK, RST_N      clock (rising edge), asynchronous active-low reset
//   REQ, MSG_IN     per-requester request level and packed messages
//   ACK, ERR        one-cycle pulses: message accepted / start timeout
//   BUSY, GNT_ID    arbiter not idle / current or last granted requester
//   TX_EN, TX_MSG   transmitter enable and message (held while TX_EN=1)
//   TX_SB           transmitter stand-by count (constant SB_CYC)
//   TX_SEND         transmitter state_send, marks frame start
module serial_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MSG_W   = 4,
    parameter int SB_CYC  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [N_REQ-1:0]           REQ,
    input  logic [N_REQ*MSG_W-1:0]     MSG_IN,
    output logic [N_REQ-1:0]           ACK,
    output logic                       ERR,
    output logic                       BUSY,
    output logic [$clog2(N_REQ)-1:0]   GNT_ID,
    output logic                       TX_EN,
    output logic [MSG_W-1:0]           TX_MSG,
    output logic [3:0]                 TX_SB,
    input  logic                       TX_SEND
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int FRAME   = MSG_W + SB_CYC;
    localparam int CNT_MAX = (TIMEOUT > FRAME) ? TIMEOUT : FRAME;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     gnt_q, gnt_d;
    logic [MSG_W-1:0]    tx_msg_q, tx_msg_d;
    logic                tx_en_q, tx_en_d;
    logic                busy_q, busy_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                err_q, err_d;

    logic                any_req;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     scan_idx;

    // Scan from the farthest position back towards the pointer so the last
    // hit is the first requester at or after the pointer (wrapping).
    always_comb begin
        any_req  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (REQ[scan_idx]) begin
                any_req = 1'b1;
                win_id  = scan_idx;
            end
        end
    end

    // The single counter serves as start timeout in S_WAIT and frame length
    // in S_SEND; the two uses never overlap.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            tx_msg_q <= '0;
            tx_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            tx_msg_q <= tx_msg_d;
            tx_en_q  <= tx_en_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(TIMEOUT - 1);
                end
            end
            S_WAIT: begin
                if (TX_SEND) begin
                    state_d = S_SEND;
                    cnt_d   = CNT_W'(FRAME - 1);
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SEND: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every exit lands in S_IDLE, so TX_EN is low for at least one cycle
    // between frames and the transmitter re-arms.
    always_comb begin
        tx_en_d  = (state_d != S_IDLE);
        busy_d   = (state_d != S_IDLE);
        tx_msg_d = tx_msg_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        ack_d    = '0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    tx_msg_d = MSG_W'(MSG_IN >> (int'(win_id) * MSG_W));
                    gnt_d    = win_id;
                    ptr_d    = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
                end
            end
            S_WAIT: begin
                if (TX_SEND) begin
                    ack_d = N_REQ'(1) << gnt_q;
                end else if (cnt_q == '0) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ACK    = ack_q;
    assign ERR    = err_q;
    assign BUSY   = busy_q;
    assign GNT_ID = gnt_q;
    assign TX_EN  = tx_en_q;
    assign TX_MSG = tx_msg_q;
    assign TX_SB  = 4'(SB_CYC);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - randomized scoreboard bench for serial_tx_arbiter
module tb_serial_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int MSG_W   = 4;
    localparam int SB_CYC  = 3;
    localparam int TIMEOUT = 16;
    localparam int FRAME   = MSG_W + SB_CYC;

    logic                   CLK = 1'b0;
    logic                   RST_N = 1'b0;
    logic [N_REQ-1:0]       REQ = '0;
    logic [N_REQ*MSG_W-1:0] MSG_IN = '0;
    logic                   TX_SEND = 1'b0;
    logic [N_REQ-1:0]       ACK;
    logic                   ERR;
    logic                   BUSY;
    logic [1:0]             GNT_ID;
    logic                   TX_EN;
    logic [MSG_W-1:0]       TX_MSG;
    logic [3:0]             TX_SB;

    serial_tx_arbiter #(
        .N_REQ(N_REQ), .MSG_W(MSG_W), .SB_CYC(SB_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .MSG_IN(MSG_IN),
        .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .GNT_ID(GNT_ID),
        .TX_EN(TX_EN), .TX_MSG(TX_MSG), .TX_SB(TX_SB), .TX_SEND(TX_SEND)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    int edge_cnt = 0;
    initial forever begin
        @(posedge CLK);
        edge_cnt++;
    end

    // One record per predicted grant; ok=1 means ACK at end_e, else ERR at end_e.
    typedef struct {
        int gnt;
        int msg;
        int start;
        bit ok;
        int end_e;
        int fall;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state, in absolute clock-edge numbers.
    int m_ptr = 0, free_edge = 0, send_edge = -1, end_edge = -1;
    int m_gnt = -1, m_start = -1, m_fall = -1;
    bit gen_on = 0, mon_en = 0;

    // Drives inputs for the coming edge n and predicts what that edge does.
    task automatic drive_cycle();
        int n, w, d, sel;
        logic [N_REQ-1:0] r;
        exp_t e;
        n = edge_cnt + 1;
        r = REQ & ~ACK;
        if (gen_on)
            for (int i = 0; i < N_REQ; i++)
                if ($urandom_range(0, 5) == 0) r = r | (N_REQ'(1) << i);
        if (m_gnt >= 0 && n > m_start + 1 && n <= m_fall && $urandom_range(0, 15) == 0)
            r = r & ~(N_REQ'(1) << m_gnt);
        REQ = r;
        if ($urandom_range(0, 1) == 1) MSG_IN = (N_REQ*MSG_W)'($urandom);
        TX_SEND = (n == send_edge) ||
                  (send_edge >= 0 && n > send_edge && n <= end_edge && $urandom_range(0, 2) == 0);
        if (n >= free_edge && r != '0) begin
            w = m_ptr;
            while (((r >> w) & N_REQ'(1)) == '0) w = (w + 1) % N_REQ;
            m_ptr   = (w + 1) % N_REQ;
            e.gnt   = w;
            e.msg   = int'((MSG_IN >> (w * MSG_W)) & ((1 << MSG_W) - 1));
            e.start = n;
            sel = $urandom_range(0, 7);
            if (gen_on && sel == 0) begin
                e.ok = 0; e.end_e = n + TIMEOUT; e.fall = n + TIMEOUT;
                send_edge = -1; end_edge = -1;
            end else begin
                d = (sel == 1) ? TIMEOUT : $urandom_range(1, 4);
                e.ok = 1; e.end_e = n + d; e.fall = n + d + FRAME;
                send_edge = n + d; end_edge = e.fall;
            end
            m_gnt = w; m_start = n; m_fall = e.fall;
            free_edge = e.fall + 1;
            exp_q.push_back(e);
        end
    endtask

    exp_t cur;
    bit active = 0, saw_end = 0, prev_en = 0;
    int last_gnt = 0;

    initial forever begin
        @(negedge CLK);
        if (mon_en) begin
            if (TX_EN && !prev_en) begin
                if (exp_q.size() == 0) begin
                    chk("grant_queue", exp_q.size(), 1);
                end else begin
                    cur = exp_q.pop_front();
                    active = 1; saw_end = 0; last_gnt = cur.gnt;
                    chk("grant_edge", edge_cnt, cur.start);
                    chk("grant_id", int'(GNT_ID), cur.gnt);
                    chk("grant_msg", int'(TX_MSG), cur.msg);
                end
            end else if (active && TX_EN) begin
                chk("msg_hold", int'(TX_MSG), cur.msg);
                chk("gnt_hold", int'(GNT_ID), cur.gnt);
            end
            if (!TX_EN) chk("gnt_idle", int'(GNT_ID), last_gnt);
            if (ACK != '0) begin
                if (!active) chk("ack_unexpected", int'(ACK), 0);
                else begin
                    chk("ack_vec", int'(ACK), 1 << cur.gnt);
                    chk("ack_edge", edge_cnt, cur.ok ? cur.end_e : -1);
                    saw_end = 1;
                end
            end
            if (ERR) begin
                if (!active) chk("err_unexpected", int'(ERR), 0);
                else begin
                    chk("err_edge", edge_cnt, cur.ok ? -1 : cur.end_e);
                    saw_end = 1;
                end
            end
            if (!TX_EN && prev_en && active) begin
                chk("fall_edge", edge_cnt, cur.fall);
                chk("frame_closed", int'(saw_end), 1);
                active = 0;
            end
            chk("busy", int'(BUSY), int'(TX_EN));
        end
        prev_en = TX_EN;
    end

    initial begin
        repeat (2) begin
            @(negedge CLK);
            chk("rst_tx_en", int'(TX_EN), 0);
            chk("rst_busy", int'(BUSY), 0);
            chk("rst_gnt", int'(GNT_ID), 0);
            chk("rst_ack", int'(ACK), 0);
            chk("rst_err", int'(ERR), 0);
            chk("rst_msg", int'(TX_MSG), 0);
            chk("tx_sb", int'(TX_SB), SB_CYC);
        end
        RST_N = 1'b1;
        gen_on = 1;
        mon_en = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            drive_cycle();
        end
        gen_on = 0;
        for (int c = 0; c < 600 && (REQ != '0 || exp_q.size() != 0 || active || edge_cnt <= free_edge); c++) begin
            @(negedge CLK);
            drive_cycle();
        end
        @(negedge CLK);
        chk("drain_idle", int'(REQ == '0 && exp_q.size() == 0 && !active && !TX_EN), 1);

        // Reset in the middle of a frame, then check the pointer restarted.
        mon_en = 0;
        TX_SEND = 1'b0;
        MSG_IN = 16'h0500;
        REQ = 4'b0100;
        @(negedge CLK);
        chk("mid_gnt_en", int'(TX_EN), 1);
        chk("mid_gnt_id", int'(GNT_ID), 2);
        chk("mid_gnt_msg", int'(TX_MSG), 5);
        TX_SEND = 1'b1;
        MSG_IN = 16'h0a00;
        @(negedge CLK);
        TX_SEND = 1'b0;
        REQ = '0;
        chk("mid_ack", int'(ACK), 4);
        chk("mid_msg_frozen", int'(TX_MSG), 5);
        repeat (3) @(negedge CLK);
        chk("mid_sending", int'(TX_EN), 1);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_en", int'(TX_EN), 0);
        chk("mid_rst_busy", int'(BUSY), 0);
        chk("mid_rst_gnt", int'(GNT_ID), 0);
        chk("mid_rst_ack", int'(ACK), 0);
        chk("mid_rst_msg", int'(TX_MSG), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        REQ = 4'b1010;
        @(negedge CLK);
        chk("post_rst_en", int'(TX_EN), 1);
        chk("post_rst_ptr", int'(GNT_ID), 1);
        REQ = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
